// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher. Round keys are fetched from an
// external store through the round index; NUM_SBOX trades S-box area for latency.
module aes_inv_cipher_iter #(
  parameter int NUM_SBOX = 16,
  parameter bit EN_192   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic [1:0]   keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         busy,
  output logic         ready
);

  localparam int S = 16 / NUM_SBOX;

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, x);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, x);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, x);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, x);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, x);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  state_t state, state_d;
  logic [1:0]  sub;
  logic [3:0]  nr;
  logic        legal, last_sub;

  // Byte arrays are indexed by AES byte number (0 = block[127:120], column-major).
  logic [15:0][7:0]          st_b, rk_b, isr_b, sb_b, t_b, mc_b, tmp;
  logic [NUM_SBOX-1:0][7:0]  lane_in, lane_out;
  logic [127:0]              t_vec, mc_vec;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign st_b[i]  = new_block[127-8*i -: 8];
    assign rk_b[i]  = round_key[127-8*i -: 8];
    assign isr_b[i] = st_b[(i%4) + 4*(((i/4) + 4 - (i%4)) % 4)];
    // Lanes of the current sub-cycle come straight from the S-boxes, the rest from tmp.
    assign sb_b[i]  = (sub == 2'(i / NUM_SBOX)) ? lane_out[i % NUM_SBOX] : tmp[i];
    assign t_b[i]   = sb_b[i] ^ rk_b[i];
    assign t_vec[127-8*i -: 8]  = t_b[i];
    assign mc_vec[127-8*i -: 8] = mc_b[i];
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    assign lane_in[j]  = isr_b[4'(int'(sub) * NUM_SBOX + j)];
    assign lane_out[j] = inv_sbox(lane_in[j]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign {mc_b[4*c], mc_b[4*c+1], mc_b[4*c+2], mc_b[4*c+3]} =
      inv_mix_col({t_b[4*c], t_b[4*c+1], t_b[4*c+2], t_b[4*c+3]});
  end

  always_comb begin
    nr    = 4'd10;
    legal = 1'b0;
    case (keylen)
      2'b00:   begin nr = 4'd10; legal = 1'b1;   end
      2'b01:   begin nr = 4'd12; legal = EN_192; end
      2'b10:   begin nr = 4'd14; legal = 1'b1;   end
      default: ;
    endcase
  end

  assign last_sub = (sub == 2'(S - 1));
  assign busy     = (state == INIT) || (state == ROUND);
  assign ready    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (next && legal) state_d = INIT;
      INIT:       state_d = ROUND;
      ROUND:      if (last_sub && round == 4'd0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_block <= '0;
      round     <= '0;
      sub       <= '0;
      tmp       <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (next && legal) begin
          new_block <= block;
          round     <= nr;
          sub       <= '0;
        end
        INIT: begin
          new_block <= new_block ^ round_key;
          round     <= round - 4'd1;
        end
        ROUND: begin
          tmp <= sb_b;
          if (last_sub) begin
            sub <= '0;
            if (round != 4'd0) begin
              new_block <= mc_vec;
              round     <= round - 4'd1;
            end else begin
              new_block <= t_vec;
            end
          end else begin
            sub <= sub + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench: four cores (16/8/4 S-boxes, plus 16 with AES-192 disabled)
// checked against a forward-cipher reference and FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

  typedef struct {
    logic [127:0] pt;
    int           start;
    int           lat;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   nxt;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [3:0]   rnd [4];
  logic [127:0] rk  [4];
  logic [127:0] nb  [4];
  logic [3:0]   busy, ready;

  logic [127:0] ks [4][16];
  logic [127:0] ks_tmp [16];
  logic [7:0]   sbox_t [256];
  sb_t          q [4][$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk[0] = ks[0][rnd[0]];
  assign rk[1] = ks[1][rnd[1]];
  assign rk[2] = ks[2][rnd[2]];
  assign rk[3] = ks[3][rnd[3]];

  aes_inv_cipher_iter #(.NUM_SBOX(16), .EN_192(1'b1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .next(nxt[0]), .keylen(keylen), .block(block),
    .round(rnd[0]), .round_key(rk[0]), .new_block(nb[0]), .busy(busy[0]), .ready(ready[0]));
  aes_inv_cipher_iter #(.NUM_SBOX(8), .EN_192(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .next(nxt[1]), .keylen(keylen), .block(block),
    .round(rnd[1]), .round_key(rk[1]), .new_block(nb[1]), .busy(busy[1]), .ready(ready[1]));
  aes_inv_cipher_iter #(.NUM_SBOX(4), .EN_192(1'b1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .next(nxt[2]), .keylen(keylen), .block(block),
    .round(rnd[2]), .round_key(rk[2]), .new_block(nb[2]), .busy(busy[2]), .ready(ready[2]));
  aes_inv_cipher_iter #(.NUM_SBOX(16), .EN_192(1'b0)) u_n192 (
    .clk(clk), .rst_n(rst_n), .next(nxt[3]), .keylen(keylen), .block(block),
    .round(rnd[3]), .round_key(rk[3]), .new_block(nb[3]), .busy(busy[3]), .ready(ready[3]));

  function automatic int s_of(input int d);
    return (d == 1) ? 2 : (d == 2) ? 4 : 1;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // SubBytes then ShiftRows: out[r][c] = S(in[r][(c+r) mod 4]).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
      o[127-8*i -: 8] = sbox_t[s[127-8*src -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                           a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                           a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                           gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ ks_tmp[0];
    for (int r = 1; r <= nr; r++) begin
      s = sub_shift(s);
      if (r != nr) s = mix_cols(s);
      s = s ^ ks_tmp[r];
    end
    return s;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks_tmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [3:0] mask, input logic [1:0] kl, input logic [255:0] key,
                       input logic [127:0] ct, input logic [127:0] pt);
    int  nr;
    sb_t e;
    nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    expand(key, nr - 6);
    for (int d = 0; d < 4; d++) begin
      if (mask[d]) begin
        for (int r = 0; r < 16; r++) ks[d][r] = ks_tmp[r];
        if (kl == 2'b00 || kl == 2'b10 || (kl == 2'b01 && d != 3)) begin
          e.pt = pt; e.start = cyc + 1; e.lat = 1 + nr * s_of(d);
          q[d].push_back(e);
        end
      end
    end
    keylen = kl;
    block  = ct;
    nxt    = mask;
    @(negedge clk);
    nxt = '0;
  endtask

  task automatic rand_vec(input logic [1:0] kl, output logic [255:0] key,
                          output logic [127:0] pt, output logic [127:0] ct);
    int nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pt  = {$urandom, $urandom, $urandom, $urandom};
    expand(key, nr - 6);
    ct = encrypt(pt, nr);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, want 0",
               q[0].size() + q[1].size() + q[2].size() + q[3].size(), budget);
      for (int d = 0; d < 4; d++) q[d].delete();
    end
  endtask

  task automatic monitor();
    logic [3:0] prev = '0;
    sb_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (rst_n && ready[d] && !prev[d]) begin
          if (q[d].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ready dut%0d: got ready with new_block %h, want no result", d, nb[d]);
          end else begin
            e = q[d].pop_front();
            chk($sformatf("plaintext dut%0d", d), nb[d], e.pt);
            chk($sformatf("latency dut%0d", d), 128'(cyc - e.start), 128'(e.lat));
          end
        end
      end
      prev = ready;
    end
  endtask

  initial begin
    logic [255:0] key;
    logic [127:0] pt, ct;
    logic         bad;
    int           n;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0;
      logic [7:0] b;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int d = 0; d < 4; d++) for (int r = 0; r < 16; r++) ks[d][r] = '0;

    rst_n = 1'b0; nxt = '0; keylen = '0; block = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset new_block dut%0d", d), nb[d], '0);
      chk($sformatf("reset round dut%0d", d), 128'(rnd[d]), '0);
      chk($sformatf("reset busy/ready dut%0d", d), 128'({busy[d], ready[d]}), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    fork monitor(); join_none

    // AES-192 FIPS vector; the EN_192=0 core must stay idle
    start(4'hF, 2'b01, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
          128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_FIPS);
    bad = 1'b0;
    repeat (15) begin bad = bad | busy[3] | ready[3]; @(negedge clk); end
    chk("en192_off busy/ready", 128'(bad), '0);
    chk("en192_off new_block", nb[3], '0);
    wait_idle(200);

    // AES-128 FIPS vector with round sequence on the 16-lane core
    start(4'hF, 2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_FIPS);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("round128 k%0d", k), 128'(rnd[0]), 128'((k == 0) ? 10 : 10 - k));
      @(negedge clk);
    end
    wait_idle(200);

    // AES-256 FIPS vector with round hold checks on the 4-lane core
    start(4'hF, 2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
          128'h8ea2b7ca516745bfeafc49904b496089, PT_FIPS);
    for (int k = 0; k <= 56; k++) begin
      chk($sformatf("round256 k%0d", k), 128'(rnd[2]), 128'((k == 0) ? 14 : 13 - (k - 1) / 4));
      @(negedge clk);
    end
    wait_idle(200);

    // reserved keylen from DONE is ignored
    keylen = 2'b11; block = {$urandom, $urandom, $urandom, $urandom}; nxt = 4'hF;
    @(negedge clk);
    nxt = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("kl11 new_block dut%0d", d), nb[d], PT_FIPS);
      chk($sformatf("kl11 busy/ready dut%0d", d), 128'({busy[d], ready[d]}), 128'(2'b01));
    end

    // back-to-back restart in the DONE cycle
    rand_vec(2'b00, key, pt, ct);
    start(4'b0001, 2'b00, key, ct, pt);
    n = 0;
    while (!ready[0] && n < 40) begin @(negedge clk); n++; end
    chk("b2b first done", 128'(n < 40), 128'(1));
    rand_vec(2'b00, key, pt, ct);
    start(4'b0001, 2'b00, key, ct, pt);
    chk("b2b ready pulse", 128'(ready[0]), '0);
    wait_idle(200);

    // next in the middle of ROUND is ignored
    rand_vec(2'b10, key, pt, ct);
    start(4'b0100, 2'b10, key, ct, pt);
    repeat (20) @(negedge clk);
    keylen = 2'b00; block = {$urandom, $urandom, $urandom, $urandom}; nxt = 4'b0100;
    @(negedge clk);
    nxt = '0;
    wait_idle(200);

    // asynchronous reset during round 5 of AES-128
    rand_vec(2'b00, key, pt, ct);
    start(4'b0001, 2'b00, key, ct, pt);
    repeat (5) @(negedge clk);
    chk("pre-reset round", 128'(rnd[0]), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("midreset new_block", nb[0], '0);
    chk("midreset round", 128'(rnd[0]), '0);
    chk("midreset busy/ready", 128'({busy[0], ready[0]}), '0);
    q[0].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomised vectors, all cores, each key length
    for (int kl = 0; kl < 3; kl++) begin
      for (int v = 0; v < 100; v++) begin
        rand_vec(2'(kl), key, pt, ct);
        start(4'hF, 2'(kl), key, ct, pt);
        wait_idle(200);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
